dem4_bcd_scan: RTL and testbench
================================

Name: dem4_bcd_scan

Overview:
- Stage directly downstream of the 1 Hz divider; consumes its square-wave output `q` on `tick_in`.
- Counts rising edges of `tick_in` on a 4-digit BCD up/down counter, range 0000–9999.
- Drives a 4-digit multiplexed common-anode 7-segment display on the board.

Parameters:
- SCAN_N, 16: width of the free-running scan counter; its top 2 bits select the digit.
  - 16 gives a 50 MHz / 2^14 ≈ 3.05 kHz digit rate and ≈ 763 Hz frame rate.

Ports:
- clk      input   1   system clock, 50 MHz; same domain as the divider.
- reset    input   1   synchronous, active-high reset.
- tick_in  input   1   1 Hz square wave (level); each rising edge is one count event.
- en       input   1   count enable; 0 = hold.
- up       input   1   direction; 1 = increment, 0 = decrement.
- clr      input   1   synchronous clear of the count to 0000.
- bcd      output  16  count {thousands, hundreds, tens, ones}, 4 bits per digit.
- carry    output  1   one-cycle pulse on wrap 9999→0000 (up) or 0000→9999 (down).
- seg      output  7   segments gfedcba, active-low.
- an       output  4   digit anodes, active-low; an[0] = ones digit.

Behaviour:
- Reset values, applied at a clk edge with reset=1:
  - bcd = 0x0000, carry = 0, tick_d = 0, scan counter = 0.
  - an = 4'b1110, seg = 7'b1000000 (digit "0").
- Edge detect:
  - tick_d <= tick_in every cycle.
  - event = tick_in & ~tick_d & en (combinational).
  - No synchronizer; tick_in is in the clk domain.
- Latency: bcd and carry change at the first clk edge where tick_in=1 and tick_d=0.
  - They are visible in the following cycle, one cycle after tick_in first reads high.
- Priority: reset > clr > event.
  - clr=1: bcd <= 0, carry <= 0, any concurrent event is dropped.
  - tick_d still updates during clr.
- en=0 during a tick_in rising edge: the edge is lost, not deferred.
- Raising en while tick_in=1 does not produce an event.
- Up count:
  - Ones increments; digit 9 → 0 with carry into the next digit, rippling through all four digits in the same cycle.
  - 9999 → 0000 sets carry=1 for exactly one cycle.
- Down count:
  - Digit 0 → 9 with borrow from the next digit.
  - 0000 → 9999 sets carry=1 for exactly one cycle.
- carry = 0 in every cycle without a wrap event.
- Digit values are always 0–9; no invalid BCD is reachable.
- Direction may change between any two events; it takes effect on the next event.
- Scan:
  - SCAN_N-bit counter increments every cycle and wraps freely.
  - sel = scan[SCAN_N-1:SCAN_N-2].
  - sel 0 → ones / an=1110; 1 → tens / 1101; 2 → hundreds / 1011; 3 → thousands / 0111.
- seg/an are registered from sel and the current bcd (one-cycle lag).
  - Exactly one an bit is low in every cycle, including reset.
- Segment map (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any other code = 1111111 (blank, defensive only).
- Reset asserted mid-count: all state returns to reset values at that edge.
  - A tick_in already high at reset release does not count.
  - tick_d has captured 1 by the first cycle after release.

Decomposition:
- Shared package (dem4_pkg):
  - Segment pattern constants SEG_0..SEG_9 and SEG_BLANK.
  - Anode codes AN_D0..AN_D3.
  - Constant BCD_MAX_DIGIT = 4'd9.
- One sub-module: bcd_to_7seg, a combinational 4-bit BCD → 7-bit active-low decoder using the package constants.
- Counter, edge detect and scan stay in the top level.

Test Plan:
- Reset, then 12 tick_in rising edges with en=1, up=1 → bcd=0x0012, carry never asserted.
- Preload to 0x9999 via 9999 up-events (or force); one more edge → bcd=0x0000, carry=1 for one cycle, then 0.
- From 0x0000 with up=0, one edge → bcd=0x9999 and carry pulses once; next edge → 0x9998.
- From 0x0010 with up=1, en=0 across 3 edges → bcd stays 0x0010.
- clr=1 coincident with a rising edge at 0x0457 → bcd=0x0000, carry=0.
- Scan check at bcd=0x1234, SCAN_N=4 → an cycles 1110, 1101, 1011, 0111 with seg 0011001, 0110000, 0100100, 1111001, each held 4 cycles.

Source files
------------

// File: rtl/dem4_pkg.sv
// Shared constants for the 4-digit BCD counter / 7-segment scan block.
// Segment patterns are gfedcba, active-low; anode codes are active-low.
package dem4_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_D0 = 4'b1110;
    localparam logic [3:0] AN_D1 = 4'b1101;
    localparam logic [3:0] AN_D2 = 4'b1011;
    localparam logic [3:0] AN_D3 = 4'b0111;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-low 7-segment (gfedcba) decoder.
// Codes 10..15 cannot occur from the counter; they blank the digit.
module bcd_to_7seg
    import dem4_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Map one BCD digit onto its segment pattern.
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/dem4_bcd_scan.sv
// 4-digit BCD up/down event counter driven by rising edges of tick_in,
// with a multiplexed common-anode 7-segment display scanner.
module dem4_bcd_scan
    import dem4_pkg::*;
#(
    parameter int SCAN_N = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_in,
    input  logic        en,
    input  logic        up,
    input  logic        clr,
    output logic [15:0] bcd,
    output logic        carry,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    logic              tick_d;
    logic              armed;
    logic              event_p0;
    logic [15:0]       bcd_nxt;
    logic              wrap;
    logic [SCAN_N-1:0] scan;
    logic [1:0]        sel;
    logic [3:0]        cur_digit;
    logic [3:0]        an_nxt;
    logic [6:0]        seg_nxt;

    // armed blocks the first cycle after reset release, so a tick_in that
    // is already high when reset drops is absorbed into tick_d, not counted.
    assign event_p0 = tick_in & ~tick_d & en & armed;

    // Edge-detect history and post-reset arming.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_d <= 1'b0;
            armed  <= 1'b0;
        end else begin
            tick_d <= tick_in;
            armed  <= 1'b1;
        end
    end

    // Next count: ripple increment/decrement through all four digits.
    always_comb begin
        logic [3:0] dig;
        logic       c;
        bcd_nxt = bcd;
        c       = 1'b1;
        dig     = 4'd0;
        for (int i = 0; i < 4; i++) begin
            dig = bcd[4*i +: 4];
            if (c) begin
                if (up) begin
                    if (dig == BCD_MAX_DIGIT) begin
                        dig = 4'd0;
                    end else begin
                        dig = dig + 4'd1;
                        c   = 1'b0;
                    end
                end else begin
                    if (dig == 4'd0) begin
                        dig = BCD_MAX_DIGIT;
                    end else begin
                        dig = dig - 4'd1;
                        c   = 1'b0;
                    end
                end
            end
            bcd_nxt[4*i +: 4] = dig;
        end
        wrap = c;
    end

    // Count register with reset > clr > event priority; carry is a pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            bcd   <= 16'h0000;
            carry <= 1'b0;
        end else if (clr) begin
            bcd   <= 16'h0000;
            carry <= 1'b0;
        end else if (event_p0) begin
            bcd   <= bcd_nxt;
            carry <= wrap;
        end else begin
            carry <= 1'b0;
        end
    end

    // Free-running scan counter; its top two bits pick the digit.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan <= '0;
        end else begin
            scan <= scan + 1'b1;
        end
    end

    assign sel = scan[SCAN_N-1:SCAN_N-2];

    // Select the digit and anode code for the current scan slot.
    always_comb begin
        cur_digit = bcd[3:0];
        an_nxt    = AN_D0;
        case (sel)
            2'd0: begin cur_digit = bcd[3:0];   an_nxt = AN_D0; end
            2'd1: begin cur_digit = bcd[7:4];   an_nxt = AN_D1; end
            2'd2: begin cur_digit = bcd[11:8];  an_nxt = AN_D2; end
            2'd3: begin cur_digit = bcd[15:12]; an_nxt = AN_D3; end
            default: begin cur_digit = bcd[3:0]; an_nxt = AN_D0; end
        endcase
    end

    bcd_to_7seg u_dec (
        .digit (cur_digit),
        .seg   (seg_nxt)
    );

    // Register display outputs; reset shows "0" on the ones digit.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg <= SEG_0;
            an  <= AN_D0;
        end else begin
            seg <= seg_nxt;
            an  <= an_nxt;
        end
    end

endmodule

// File: tb/tb_dem4_bcd_scan.sv
// Directed bench for dem4_bcd_scan (SCAN_N = 4 so the scan is observable).
module tb_dem4_bcd_scan;

    logic        clk;
    logic        reset;
    logic        tick_in;
    logic        en;
    logic        up;
    logic        clr;
    logic [15:0] bcd;
    logic        carry;
    logic [6:0]  seg;
    logic [3:0]  an;

    int errors;
    int checks;
    int carry_seen;

    dem4_bcd_scan #(.SCAN_N(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .tick_in (tick_in),
        .en      (en),
        .up      (up),
        .clr     (clr),
        .bcd     (bcd),
        .carry   (carry),
        .seg     (seg),
        .an      (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full tick_in period: high for one cycle, low for one cycle.
    task automatic edge_tick(input int n);
        for (int k = 0; k < n; k++) begin
            tick_in = 1'b1;
            step();
            if (carry) carry_seen++;
            tick_in = 1'b0;
            step();
            if (carry) carry_seen++;
        end
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
        step();
    endtask

    initial begin
        logic [3:0] an_exp  [4];
        logic [6:0] seg_exp [4];
        int found;

        errors = 0;
        checks = 0;
        carry_seen = 0;
        reset = 1'b1; tick_in = 1'b0; en = 1'b1; up = 1'b1; clr = 1'b0;

        // Reset state.
        step();
        step();
        chk("rst_bcd",   {16'h0, bcd},   32'h0000);
        chk("rst_carry", {31'h0, carry}, 32'h0);
        chk("rst_an",    {28'h0, an},    32'b1110);
        chk("rst_seg",   {25'h0, seg},   32'b1000000);
        reset = 1'b0;
        step();
        step();

        // 12 up events.
        edge_tick(12);
        chk("up12_bcd",   {16'h0, bcd}, 32'h0012);
        chk("up12_carry", carry_seen,   0);

        // Latency: count visible right after the rising-edge clock.
        tick_in = 1'b1;
        step();
        chk("lat_bcd", {16'h0, bcd}, 32'h0013);
        tick_in = 1'b0;
        step();

        // Run up to 9999, then wrap.
        edge_tick(9999 - 13);
        chk("pre9999_bcd", {16'h0, bcd}, 32'h9999);
        chk("pre9999_carry_seen", carry_seen, 0);
        tick_in = 1'b1;
        step();
        chk("wrapup_bcd",   {16'h0, bcd},   32'h0000);
        chk("wrapup_carry", {31'h0, carry}, 32'h1);
        tick_in = 1'b0;
        step();
        chk("wrapup_carry_off", {31'h0, carry}, 32'h0);

        // Down wrap 0000 -> 9999, then 9998.
        up = 1'b0;
        tick_in = 1'b1;
        step();
        chk("wrapdn_bcd",   {16'h0, bcd},   32'h9999);
        chk("wrapdn_carry", {31'h0, carry}, 32'h1);
        tick_in = 1'b0;
        step();
        chk("wrapdn_carry_off", {31'h0, carry}, 32'h0);
        tick_in = 1'b1;
        step();
        chk("dn9998_bcd",   {16'h0, bcd},   32'h9998);
        chk("dn9998_carry", {31'h0, carry}, 32'h0);
        tick_in = 1'b0;
        step();

        // Borrow ripple: 1000 -> 0999.
        do_clr();
        up = 1'b1;
        edge_tick(1000);
        chk("up1000_bcd", {16'h0, bcd}, 32'h1000);
        up = 1'b0;
        edge_tick(1);
        chk("dn0999_bcd", {16'h0, bcd}, 32'h0999);

        // Enable low drops edges; raising en while tick_in is high does not count.
        do_clr();
        up = 1'b1;
        edge_tick(10);
        chk("pre_en_bcd", {16'h0, bcd}, 32'h0010);
        en = 1'b0;
        edge_tick(3);
        chk("en0_bcd", {16'h0, bcd}, 32'h0010);
        tick_in = 1'b1;
        step();
        en = 1'b1;
        step();
        step();
        chk("en_late_bcd", {16'h0, bcd}, 32'h0010);
        tick_in = 1'b0;
        step();

        // clr wins over a coincident edge.
        do_clr();
        edge_tick(457);
        chk("pre_clr_bcd", {16'h0, bcd}, 32'h0457);
        clr = 1'b1;
        tick_in = 1'b1;
        step();
        chk("clr_bcd",   {16'h0, bcd},   32'h0000);
        chk("clr_carry", {31'h0, carry}, 32'h0);
        clr = 1'b0;
        step();
        chk("clr_hold_bcd", {16'h0, bcd}, 32'h0000);
        tick_in = 1'b0;
        step();

        // Reset mid-count with tick_in held high across release.
        edge_tick(3);
        chk("pre_rst_bcd", {16'h0, bcd}, 32'h0003);
        tick_in = 1'b1;
        reset = 1'b1;
        step();
        chk("midrst_bcd", {16'h0, bcd}, 32'h0000);
        chk("midrst_an",  {28'h0, an},  32'b1110);
        reset = 1'b0;
        step();
        step();
        step();
        chk("rel_high_bcd", {16'h0, bcd}, 32'h0000);
        tick_in = 1'b0;
        step();
        edge_tick(1);
        chk("after_rel_bcd", {16'h0, bcd}, 32'h0001);

        // Scan at 1234.
        do_clr();
        up = 1'b1;
        edge_tick(1234);
        chk("scan_bcd", {16'h0, bcd}, 32'h1234);
        an_exp[0] = 4'b1110; seg_exp[0] = 7'b0011001;
        an_exp[1] = 4'b1101; seg_exp[1] = 7'b0110000;
        an_exp[2] = 4'b1011; seg_exp[2] = 7'b0100100;
        an_exp[3] = 4'b0111; seg_exp[3] = 7'b1111001;
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            logic [3:0] an_prev;
            an_prev = an;
            step();
            if (an_prev == 4'b0111 && an == 4'b1110) found = 1;
        end
        chk("scan_sync", found, 1);
        if (found == 1) begin
            for (int k = 0; k < 16; k++) begin
                chk($sformatf("scan_an_%0d", k),  {28'h0, an},  {28'h0, an_exp[k/4]});
                chk($sformatf("scan_seg_%0d", k), {25'h0, seg}, {25'h0, seg_exp[k/4]});
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
